// File: rtl/m1_image_loader_if.sv
// -----------------------------------------------------------------------------
// m1_image_loader_if
// Pixel-stream handshake plus the M1 write port of the image loader.
//   pix_valid/pix_data/pix_last : pixel stream from the source
//   pix_ready                   : loader accepts a pixel this cycle
//   M1_WriteBus/Address/Enable  : packed-word write into M1
// Modports: master = pixel source / M1 observer, slave = the loader.
// -----------------------------------------------------------------------------
interface m1_image_loader_if #(
  parameter int PIX_W  = 8,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 12
);
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_last;
  logic              pix_ready;
  logic [WORD_W-1:0] M1_WriteBus;
  logic [ADDR_W-1:0] M1_WriteAddress;
  logic              M1_WriteEnable;

  modport master (
    output pix_valid, pix_data, pix_last,
    input  pix_ready, M1_WriteBus, M1_WriteAddress, M1_WriteEnable
  );

  modport slave (
    input  pix_valid, pix_data, pix_last,
    output pix_ready, M1_WriteBus, M1_WriteAddress, M1_WriteEnable
  );
endinterface

// File: rtl/m1_image_loader.sv
// -----------------------------------------------------------------------------
// m1_image_loader
// Producer side of the input image memory M1. Accepts a PIX_W pixel stream,
// packs PPW pixels per WORD_W word (first pixel in the LSBs) and writes
// consecutive M1 words starting at BASE_ADDR. A frame ends after NUM_PIXELS
// pixels or early on pix_last, in which case the partial word is zero-filled
// and short_frame is raised.
// Ports:
//   clock, reset_n : clock (rising edge), asynchronous active-low reset
//   frame_start    : arms a new frame (honoured only when idle)
//   bus            : pixel stream in, M1 write port out (slave modport)
//   busy           : high from arming until done
//   done           : one-cycle completion pulse
//   short_frame    : sticky, frame ended early on pix_last
// All outputs are registered.
// -----------------------------------------------------------------------------
module m1_image_loader #(
  parameter int PIX_W      = 8,
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 12,
  parameter int NUM_PIXELS = 16384,
  parameter int BASE_ADDR  = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                frame_start,
  m1_image_loader_if.slave    bus,
  output logic                busy,
  output logic                done,
  output logic                short_frame
);

  localparam int PPW       = WORD_W / PIX_W;
  localparam int LANE_W    = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int PIX_CNT_W = $clog2(NUM_PIXELS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FIN,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [LANE_W-1:0]    r_lane;
  logic [PIX_CNT_W-1:0] r_pix_cnt;
  logic [ADDR_W-1:0]    r_word_cnt;
  logic [WORD_W-1:0]    r_word_buf;

  logic                 r_pix_ready;
  logic                 r_write_en;
  logic [WORD_W-1:0]    r_write_bus;
  logic [ADDR_W-1:0]    r_write_addr;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_short_frame;

  logic                 w_accept;
  logic                 w_last_pix;
  logic                 w_lane_full;
  logic                 w_early;
  logic                 w_final;
  logic                 w_write;
  logic [WORD_W-1:0]    w_word;

  // pix_ready is registered and is high exactly while in LOAD.
  assign w_accept    = r_pix_ready & bus.pix_valid;
  assign w_last_pix  = (r_pix_cnt == PIX_CNT_W'(NUM_PIXELS - 1));
  assign w_lane_full = (r_lane == LANE_W'(PPW - 1));
  // pix_last on the nominal final pixel is not an early end.
  assign w_early     = w_accept & bus.pix_last & ~w_last_pix;
  assign w_final     = w_accept & (w_last_pix | bus.pix_last);
  assign w_write     = w_accept & (w_lane_full | w_final);

  // Current word with the incoming pixel merged into its lane. Lanes above
  // the current one are still zero in r_word_buf, which gives the zero-fill
  // of a partial word for free.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_word = r_word_buf;
    for (int k = 0; k < PPW; k++) begin
      if (r_lane == LANE_W'(k)) begin
        w_word[PIX_W*k +: PIX_W] = bus.pix_data;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (frame_start) w_next_state = S_LOAD;
      S_LOAD: if (w_final)     w_next_state = S_FIN;
      S_FIN:                   w_next_state = S_DONE;
      S_DONE:                  w_next_state = S_IDLE;
      default:                 w_next_state = S_IDLE;
    endcase
  end

  // State register and the status outputs derived from the next state, so
  // they line up with r_state without a combinational output path.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_state     <= S_IDLE;
      r_pix_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_pix_ready <= (w_next_state == S_LOAD);
      r_busy      <= (w_next_state != S_IDLE);
      r_done      <= (w_next_state == S_DONE);
    end
  end

  // Lane / pixel / word counters, packing buffer and the sticky short flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lane        <= '0;
      r_pix_cnt     <= '0;
      r_word_cnt    <= '0;
      r_word_buf    <= '0;
      r_short_frame <= 1'b0;
    end else if ((r_state == S_IDLE) && frame_start) begin
      r_lane        <= '0;
      r_pix_cnt     <= '0;
      r_word_cnt    <= '0;
      r_word_buf    <= '0;
      r_short_frame <= 1'b0;
    end else if (w_accept) begin
      r_pix_cnt <= r_pix_cnt + PIX_CNT_W'(1);
      if (w_write) begin
        r_lane     <= '0;
        r_word_buf <= '0;
        r_word_cnt <= r_word_cnt + ADDR_W'(1);
      end else begin
        r_lane     <= r_lane + LANE_W'(1);
        r_word_buf <= w_word;
      end
      if (w_early) begin
        r_short_frame <= 1'b1;
      end
    end
  end

  // M1 write port: one-cycle strobe; bus and address hold between writes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_write_en   <= 1'b0;
      r_write_bus  <= '0;
      r_write_addr <= ADDR_W'(BASE_ADDR);
    end else begin
      r_write_en <= w_write;
      if (w_write) begin
        r_write_bus  <= w_word;
        r_write_addr <= ADDR_W'(BASE_ADDR) + r_word_cnt;
      end
    end
  end

  assign bus.pix_ready       = r_pix_ready;
  assign bus.M1_WriteEnable  = r_write_en;
  assign bus.M1_WriteBus     = r_write_bus;
  assign bus.M1_WriteAddress = r_write_addr;
  assign busy                = r_busy;
  assign done                = r_done;
  assign short_frame         = r_short_frame;

endmodule

// File: doc/m1_image_loader.md
# m1_image_loader

Writer for the input image memory M1. Accepts an 8-bit pixel stream over a valid/ready handshake, packs four pixels per 32-bit word, and writes consecutive M1 words from `BASE_ADDR`. It signals frame completion so the controller can launch the histogram input pipeline, which reads M1 through `M1_ReadBus1`/`M1_ReadAddress1`. This block is the producer side of that memory.

## Interface
Parameters:
- `PIX_W`, 8, pixel width in bits.
- `WORD_W`, 32, M1 word width; `PPW = WORD_W/PIX_W` = 4 pixels per word.
- `ADDR_W`, 12, M1 address width.
- `NUM_PIXELS`, 16384, pixels per frame; must be a multiple of `PPW` and at most `PPW*2^ADDR_W`.
- `BASE_ADDR`, 0, M1 word address of pixel 0.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `frame_start`  in  1  pulse; arms a new frame load.
- `pix_valid`  in  1  pixel present on `pix_data`.
- `pix_data`  in  PIX_W  pixel value.
- `pix_last`  in  1  qualifies the current pixel as the last one of the frame.
- `pix_ready`  out  1  loader accepts a pixel this cycle.
- `M1_WriteBus`  out  WORD_W  packed word.
- `M1_WriteAddress`  out  ADDR_W  word address.
- `M1_WriteEnable`  out  1  write strobe, one cycle per word.
- `busy`  out  1  high from arming until `done`.
- `done`  out  1  one-cycle completion pulse.
- `short_frame`  out  1  sticky; the frame ended early on `pix_last`.

## Operation
- A pixel is accepted when `pix_valid & pix_ready` are high at a rising edge.
- States:
  - IDLE: `pix_ready`=0. `frame_start` moves to LOAD and clears the lane count, the word count and `short_frame`.
  - LOAD: `pix_ready`=1. Each accepted pixel fills the next lane. Pixel k of a word occupies bits `[PIX_W*k +: PIX_W]`, so the first pixel sits in the LSBs.
  - FIN: the final write is in flight; `pix_ready`=0.
  - DONE: `done`=1 for one cycle, then return to IDLE.
- Word write: on the edge that accepts lane `PPW-1`, register the full word, set the address to `BASE_ADDR + word_count` (modulo 2^ADDR_W), and drive `M1_WriteEnable`=1 for the next cycle only. Then increment `word_count`.
- Normal end: on the edge that accepts pixel `NUM_PIXELS-1`, perform the word write and go to FIN. The sequence is FIN then DONE then IDLE. `pix_last` on that pixel is ignored and `short_frame` stays 0.
- Early end: `pix_last` is accepted before pixel `NUM_PIXELS-1`.
  - Zero-fill the unused lanes and write the partial word (even a single lane).
  - Set `short_frame`=1 and go to FIN.
  - If the last pixel completes a word exactly, no extra word is written.
- `frame_start` is ignored outside IDLE.
- Data on `pix_data` is ignored when not accepted.
- `busy` = (state != IDLE).
- Reset mid-frame: all state returns to IDLE immediately and the partial word is discarded. No `M1_WriteEnable` glitch is allowed.

## Timing
- Reset values:
  - `pix_ready`=0, `M1_WriteEnable`=0, `M1_WriteBus`=0, `M1_WriteAddress`=`BASE_ADDR`.
  - `busy`=0, `done`=0, `short_frame`=0, state IDLE.
- `frame_start` at edge t gives `pix_ready`=1 and `busy`=1 in cycle t+1.
- All outputs are registered.
- Write latency: the word is on the bus with `M1_WriteEnable` high in the cycle immediately after the edge that accepted its last lane.
- Back-to-back words with `pix_valid` held high give one write every 4 cycles.
- Throughput is 1 pixel per cycle while in LOAD.
- Final pixel accepted at edge t:
  - cycle t+1: final `M1_WriteEnable` high, state FIN, `pix_ready`=0.
  - cycle t+2: `done`=1.
  - cycle t+3: `busy`=0.
- `short_frame` is valid from the cycle `done` is high until the next accepted `frame_start`.

## Test plan
- Full frame, `NUM_PIXELS`=16: stream bytes 0x00..0x0F with `pix_valid` always high.
  - Expect 4 writes at addresses 0..3 with data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
  - Expect `done` 2 cycles after the last accept and `short_frame`=0.
- Bubbles: insert random `pix_valid`=0 gaps into the same stream.
  - Expect identical writes, with each write 1 cycle after its 4th accept.
- Early end: `pix_last` on pixel 5 (data 0x10..0x15).
  - Expect writes 0x13121110 @0, then 0x00001514 @1.
  - Expect `short_frame`=1, `done` 2 cycles later, and no further accepts.
- Exact-word early end: `pix_last` on pixel 7.
  - Expect exactly 2 writes, `short_frame`=1, and `done` 2 cycles after the accept.
- Reset mid-frame: assert `reset_n`=0 after 6 pixels.
  - Expect all outputs at reset values asynchronously and no write of the partial word.
  - A fresh frame then writes from `BASE_ADDR`.
- Ignored start: pulse `frame_start` in the middle of LOAD.
  - Expect the counters undisturbed and the frame to complete normally.
